// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: resolves the immediate format, sign-extends to XLEN,
// computes pc + imm, and holds results in a 2-entry in-order output buffer.
module imm_gen_pipe #(
    parameter int unsigned XLEN        = 32,
    parameter bit          AUTO_DECODE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [2:0] FmtI = 3'b000;
    localparam logic [2:0] FmtS = 3'b001;
    localparam logic [2:0] FmtB = 3'b010;
    localparam logic [2:0] FmtU = 3'b011;
    localparam logic [2:0] FmtJ = 3'b100;
    localparam logic [2:0] FmtZ = 3'b101;
    localparam logic [2:0] FmtX = 3'b110;
    localparam logic [2:0] FmtR = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;
    entry_t          new_entry;

    always_comb begin
        dec_fmt     = FmtX;
        dec_illegal = 1'b0;
        if (AUTO_DECODE) begin
            case (in_instr[6:0])
                7'b0010011, 7'b0000011, 7'b1100111: dec_fmt = FmtI;
                7'b1110011:                         dec_fmt = in_instr[14] ? FmtZ : FmtI;
                7'b0100011:                         dec_fmt = FmtS;
                7'b1100011:                         dec_fmt = FmtB;
                7'b0110111, 7'b0010111:             dec_fmt = FmtU;
                7'b1101111:                         dec_fmt = FmtJ;
                7'b0110011:                         dec_fmt = FmtR;
                default: begin
                    dec_fmt     = FmtX;
                    dec_illegal = 1'b1;
                end
            endcase
        end else begin
            dec_fmt     = in_sel;
            dec_illegal = (in_sel == FmtX) || (in_sel == FmtR);
        end
    end

    // Every format fits in 32 bits; widening to XLEN is a single sign extension.
    always_comb begin
        dec_imm32 = '0;
        if (!dec_illegal) begin
            case (dec_fmt)
                FmtI: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                FmtS: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                FmtB: dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                   in_instr[30:25], in_instr[11:8], 1'b0};
                FmtU: dec_imm32 = {in_instr[31:12], 12'b0};
                FmtJ: dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                   in_instr[20], in_instr[30:21], 1'b0};
                FmtZ: dec_imm32 = {27'b0, in_instr[19:15]};
                default: dec_imm32 = '0;
            endcase
        end
        dec_imm = XLEN'($signed(dec_imm32));
    end

    always_comb begin
        new_entry.imm     = dec_imm;
        new_entry.target  = in_pc + dec_imm;
        new_entry.pc      = in_pc;
        new_entry.fmt     = dec_fmt;
        new_entry.illegal = dec_illegal;
    end

    entry_t     mem_q [2];
    entry_t     mem_d [2];
    logic [1:0] count_q, count_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       push, pop;
    entry_t     head;

    assign in_ready  = (count_q < 2'd2) && !reset;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
        end
    end

    // Data outputs are forced to zero whenever the buffer is empty.
    always_comb begin
        head        = mem_q[rd_ptr_q];
        out_imm     = out_valid ? head.imm : '0;
        out_target  = out_valid ? head.target : '0;
        out_pc      = out_valid ? head.pc : '0;
        out_fmt     = out_valid ? head.fmt : 3'b000;
        out_illegal = out_valid ? head.illegal : 1'b0;
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (32-bit auto, 64-bit auto, 32-bit external select)
// share one stimulus stream and are checked against a queue-based reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic [2:0]  in_sel;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32, tgt32, pc32;
    logic [2:0]  fmt32;
    logic        rdy64, vld64, ill64;
    logic [63:0] imm64, tgt64, pc64;
    logic [2:0]  fmt64;
    logic        rdym, vldm, illm;
    logic [31:0] immm, tgtm, pcm;
    logic [2:0]  fmtm;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) u_d32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .in_sel(in_sel), .out_valid(vld32),
        .out_ready(out_ready), .out_imm(imm32), .out_target(tgt32), .out_pc(pc32),
        .out_fmt(fmt32), .out_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) u_d64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_pc(in_pc), .in_sel(in_sel), .out_valid(vld64),
        .out_ready(out_ready), .out_imm(imm64), .out_target(tgt64), .out_pc(pc64),
        .out_fmt(fmt64), .out_illegal(ill64)
    );

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) u_dman (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdym),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .in_sel(in_sel), .out_valid(vldm),
        .out_ready(out_ready), .out_imm(immm), .out_target(tgtm), .out_pc(pcm),
        .out_fmt(fmtm), .out_illegal(illm)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [2:0]  sel;
    } txn_t;

    txn_t q[$];
    int   ntests = 0;
    int   nfail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Two's-complement interpretation of a bits-wide unsigned field.
    function automatic longint sext(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    task automatic ref_model(input txn_t t, input bit is64, input bit auto_m,
                             output logic [63:0] imm, output logic [63:0] tgt,
                             output logic [2:0] fmt, output logic ill);
        logic [31:0] w;
        longint      v;
        w   = t.instr;
        ill = 1'b0;
        if (auto_m) begin
            case (w[6:0])
                7'h13, 7'h03, 7'h67: fmt = 3'd0;
                7'h73:               fmt = w[14] ? 3'd5 : 3'd0;
                7'h23:               fmt = 3'd1;
                7'h63:               fmt = 3'd2;
                7'h37, 7'h17:        fmt = 3'd3;
                7'h6f:               fmt = 3'd4;
                7'h33:               fmt = 3'd7;
                default: begin fmt = 3'd6; ill = 1'b1; end
            endcase
        end else begin
            fmt = t.sel;
            ill = (t.sel >= 3'd6);
        end
        case (fmt)
            3'd0: v = sext(longint'(w[31:20]), 12);
            3'd1: v = sext(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
            3'd2: v = sext(longint'(w[31]) * 4096 + longint'(w[7]) * 2048
                           + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
            3'd3: v = sext(longint'(w[31:12]) * 4096, 32);
            3'd4: v = sext(longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
                           + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
            3'd5: v = longint'(w[19:15]);
            default: v = 0;
        endcase
        if (ill) v = 0;
        imm = v;
        tgt = t.pc + imm;
        if (!is64) begin
            imm[63:32] = '0;
            tgt[63:32] = '0;
        end
    endtask

    task automatic check_dut(input string nm, input bit is64, input bit auto_m,
                             input logic rdy, input logic vld, input logic [63:0] imm,
                             input logic [63:0] tgt, input logic [63:0] pc,
                             input logic [2:0] fmt, input logic ill);
        logic [63:0] e_imm, e_tgt, e_pc;
        logic [2:0]  e_fmt;
        logic        e_ill;
        e_imm = '0; e_tgt = '0; e_pc = '0; e_fmt = '0; e_ill = 1'b0;
        if (q.size() != 0) begin
            ref_model(q[0], is64, auto_m, e_imm, e_tgt, e_fmt, e_ill);
            e_pc = q[0].pc;
            if (!is64) e_pc[63:32] = '0;
        end
        chk({nm, " in_ready"}, 64'(rdy), 64'(q.size() < 2));
        chk({nm, " out_valid"}, 64'(vld), 64'(q.size() != 0));
        chk({nm, " out_imm"}, imm, e_imm);
        chk({nm, " out_target"}, tgt, e_tgt);
        chk({nm, " out_pc"}, pc, e_pc);
        chk({nm, " out_fmt"}, 64'(fmt), 64'(e_fmt));
        chk({nm, " out_illegal"}, 64'(ill), 64'(e_ill));
    endtask

    task automatic check_all();
        check_dut("d32", 1'b0, 1'b1, rdy32, vld32, 64'(imm32), 64'(tgt32), 64'(pc32), fmt32, ill32);
        check_dut("d64", 1'b1, 1'b1, rdy64, vld64, imm64, tgt64, pc64, fmt64, ill64);
        check_dut("dman", 1'b0, 1'b0, rdym, vldm, 64'(immm), 64'(tgtm), 64'(pcm), fmtm, illm);
    endtask

    // One clock: update the reference queue with the handshake seen at the edge, then check.
    task automatic cycle();
        bit   do_push, do_pop, do_flush;
        txn_t t;
        do_push  = in_valid && (q.size() < 2);
        do_pop   = (q.size() != 0) && out_ready;
        do_flush = flush;
        t.instr  = in_instr;
        t.pc     = in_pc;
        t.sel    = in_sel;
        @(posedge clk);
        if (do_flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(t);
        end
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                         input logic [2:0] sel);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
        in_sel   = sel;
    endtask

    initial begin
        logic [31:0] r;
        logic [63:0] rpc;
        logic [6:0]  ops [12];
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33,
                7'h7f, 7'h0b};

        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 64'h0, 3'd0);
        @(posedge clk); #1;
        chk("reset in_ready", 64'(rdy32), 64'd0);
        chk("reset out_valid", 64'(vld64), 64'd0);
        chk("reset out_imm", imm64, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_all();

        // I-type addi x1,x0,-1
        drive(1'b1, 32'hFFF00093, 64'h10, 3'd0);
        cycle();
        chk("itype imm", 64'(imm32), 64'hFFFFFFFF);
        chk("itype target", 64'(tgt32), 64'h0000000F);
        chk("itype fmt", 64'(fmt32), 64'd0);

        // B-type beq x0,x0,-4 replaces the I-type head in the same cycle
        out_ready = 1'b1;
        drive(1'b1, 32'hFE000EE3, 64'h100, 3'd2);
        cycle();
        chk("btype imm", 64'(imm32), 64'hFFFFFFFC);
        chk("btype target", 64'(tgt32), 64'h000000FC);
        chk("btype fmt", 64'(fmt32), 64'd2);
        drive(1'b0, 32'h0, 64'h0, 3'd0);
        cycle();

        // Backpressure: A, B, C offered back to back with consumer stalled
        out_ready = 1'b0;
        drive(1'b1, 32'h00500113, 64'h200, 3'd0);
        cycle();
        drive(1'b1, 32'h00112023, 64'h204, 3'd1);
        cycle();
        drive(1'b1, 32'h008000EF, 64'h208, 3'd4);
        cycle();
        chk("bp in_ready held", 64'(rdy32), 64'd0);
        cycle();
        out_ready = 1'b1;
        cycle();
        cycle();
        drive(1'b0, 32'h0, 64'h0, 3'd0);
        chk("bp c head pc", 64'(pc32), 64'h208);
        cycle();

        // 64-bit U-type, then an unknown opcode
        drive(1'b1, 32'h800000B7, 64'h1000, 3'd3);
        cycle();
        chk("u64 imm", imm64, 64'hFFFFFFFF80000000);
        drive(1'b1, 32'h0000007F, 64'h1004, 3'd6);
        cycle();
        chk("illegal64 flag", 64'(ill64), 64'd1);
        chk("illegal64 imm", imm64, 64'd0);
        chk("illegal64 fmt", 64'(fmt64), 64'd6);
        drive(1'b0, 32'h0, 64'h0, 3'd0);
        cycle();

        // Flush wins over a simultaneous push
        out_ready = 1'b0;
        drive(1'b1, 32'h00A00093, 64'h300, 3'd0);
        cycle();
        drive(1'b1, 32'h00B00093, 64'h304, 3'd0);
        flush = 1'b1;
        cycle();
        chk("flush out_valid", 64'(vld32), 64'd0);
        flush = 1'b0;
        drive(1'b0, 32'h0, 64'h0, 3'd0);
        cycle();
        cycle();

        // Asynchronous reset with two entries buffered
        drive(1'b1, 32'h12345037, 64'h400, 3'd3);
        cycle();
        drive(1'b1, 32'h0010006F, 64'h404, 3'd4);
        cycle();
        drive(1'b0, 32'h0, 64'h0, 3'd0);
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        chk("async rst out_valid", 64'(vld32), 64'd0);
        chk("async rst out_imm", 64'(imm32), 64'd0);
        chk("async rst in_ready", 64'(rdy64), 64'd0);
        @(posedge clk); #1;
        chk("held rst in_ready", 64'(rdym), 64'd0);
        reset = 1'b0;
        #1;
        check_all();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r   = $urandom();
            rpc = {32'($urandom()), 32'($urandom())};
            drive(1'($urandom_range(0, 3) != 0), {r[31:7], ops[$urandom_range(0, 11)]}, rpc,
                  3'($urandom_range(0, 7)));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the decode stage. It accepts one 32-bit instruction per valid/ready handshake and selects the immediate format either from the opcode or from an external select. The immediate is sign-extended to XLEN and the PC-relative target (pc + imm) is computed alongside it. Results pass through a 2-entry output buffer so that execute-stage backpressure never drops an instruction.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
AUTO_DECODE, 1, format source: 1 = derived from opcode, 0 = taken from in_sel.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous clear of the buffer.
in_valid  input  1  in_instr, in_pc and in_sel are valid this cycle.
in_ready  output  1  block can accept an instruction this cycle.
in_instr  input  32  raw instruction word.
in_pc  input  XLEN  PC of in_instr.
in_sel  input  3  format select; used only when AUTO_DECODE=0.
out_valid  output  1  head entry is valid.
out_ready  input  1  consumer takes the head entry this cycle.
out_imm  output  XLEN  sign/zero-extended immediate.
out_target  output  XLEN  out_pc + out_imm, modulo 2^XLEN.
out_pc  output  XLEN  PC carried through with the entry.
out_fmt  output  3  resolved format code.
out_illegal  output  1  unknown opcode or unknown select value.

Behaviour:
- Format codes:
  - 000 I: instr[31:20], sign-extended.
  - 001 S: {instr[31:25], instr[11:7]}, sign-extended.
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - 011 U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - 100 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - 101 Z: instr[19:15], zero-extended (CSR immediate).
  - 111 R: no immediate; imm = 0.
  - 110 is illegal.
- Opcode map when AUTO_DECODE=1:
  - 0010011, 0000011, 1100111 -> I.
  - 1110011 -> Z if funct3[2]=1, else I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - 0110011 -> R.
  - Any other opcode -> out_illegal=1, fmt=110, imm=0.
- AUTO_DECODE=0: in_sel is used directly. Values 110 and 111 give out_illegal=1 and imm=0; 111 is not illegal in auto mode.
- out_target is always computed (pc + imm), including for I/S/R formats and illegal entries.
- Buffer: 2-entry in-order FIFO; count ∈ {0,1,2}.
  - Push when in_valid & in_ready.
  - Pop when out_valid & out_ready.
- in_ready = (count < 2) & ~reset. It depends only on registered state, with no combinational path from out_ready.
- out_valid = (count != 0). Outputs come from the head entry.
- All data outputs are 0 whenever out_valid=0.
- Latency: an instruction accepted at edge N appears at the outputs after edge N (one cycle), provided the buffer was empty or the older entry pops at N.
- Simultaneous push and pop:
  - count=1: count stays 1; the new entry becomes head.
  - count=2: no push (in_ready=0); count becomes 1.
- flush=1 at an edge: count becomes 0 and all entries are invalidated. flush wins over a simultaneous push and pop; the pushed instruction is discarded.
- Reset, including mid-transfer: count=0 immediately (asynchronous).
  - out_valid=0; all data outputs 0; in_ready=0 while reset is held.
  - in_ready=1 on the first cycle after deassertion.
- Arithmetic: a single XLEN-bit adder; overflow wraps and no carry is exposed.

Test Plan:
- Reset: assert reset with 2 entries buffered -> out_valid=0 and out_imm=0 immediately, in_ready=0; deassert -> in_ready=1, count=0.
- I-type: XLEN=32, auto mode, in_instr=0xFFF00093 (addi x1,x0,-1), in_pc=0x10 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=000, out_target=0x0000000F.
- B-type: in_instr=0xFE000EE3 (beq x0,x0,-4), in_pc=0x100 -> out_imm=0xFFFFFFFC, out_fmt=010, out_target=0x000000FC.
- Backpressure: out_ready=0, offer instructions A, B, C back-to-back -> A and B accepted, in_ready=0 while C is held; raise out_ready -> A, B, C emerge in order, with no loss or duplication.
- XLEN=64 U-type: in_instr=0x800000B7 (lui x1,0x80000) -> out_imm=0xFFFFFFFF80000000; in_instr=0x0000007F -> out_illegal=1, out_imm=0, out_fmt=110.
- Flush with simultaneous push: count=1, in_valid=1 and flush=1 at the same edge -> next cycle out_valid=0 and the pushed instruction never appears.
